// File: rtl/seven_segment_pager.sv
// Two-digit seven-segment pager: shows a 16-bit word as a high-byte page and a low-byte page,
// each followed by an optional blank gap. New words take effect only at the page-cycle wrap.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | nothing committed, decoders dark
// SHOW_HI | high byte of disp on the digits for HOLD_CYCLES
// GAP_HI  | dark for GAP_CYCLES, page still 0
// SHOW_LO | low byte of disp on the digits for HOLD_CYCLES
// GAP_LO  | dark for GAP_CYCLES, page 1; its end is the wrap
module seven_segment_pager #(
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 2_500_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   output logic [3:0]  digit_left,
   output logic [3:0]  digit_right,
   output logic        blank,
   output logic        page
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam bit HAS_GAP = (GAP_CYCLES > 0);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHOW_HI = 3'd1,
      GAP_HI  = 3'd2,
      SHOW_LO = 3'd3,
      GAP_LO  = 3'd4
   } state_t;

   state_t        state, stateNext;
   logic [CW-1:0] cnt, cntNext;
   logic [15:0]   disp, dispNext;
   logic [15:0]   pend, pendNext;
   logic          pendValid, pendValidNext;
   logic          xfer, wrap;
   logic [3:0]    leftNext, rightNext;
   logic          blankNext, pageNext;

   assign load_ready = !pendValid;
   assign xfer       = load_valid && !pendValid;

   always_comb begin
      stateNext     = state;
      cntNext       = cnt;
      dispNext      = disp;
      pendNext      = pend;
      pendValidNext = pendValid;
      wrap          = 1'b0;

      if (clear) begin
         stateNext     = IDLE;
         cntNext       = '0;
         pendValidNext = 1'b0;
      end else begin
         if (state != IDLE && xfer) begin
            pendNext      = load_data;
            pendValidNext = 1'b1;
         end
         case (state)
            IDLE: begin
               if (xfer) begin
                  dispNext  = load_data;
                  cntNext   = '0;
                  stateNext = SHOW_HI;
               end
            end
            SHOW_HI: begin
               if (cnt == HOLD_LAST) begin
                  cntNext   = '0;
                  stateNext = HAS_GAP ? GAP_HI : SHOW_LO;
               end else begin
                  cntNext = cnt + CW'(1);
               end
            end
            GAP_HI: begin
               if (cnt == GAP_LAST) begin
                  cntNext   = '0;
                  stateNext = SHOW_LO;
               end else begin
                  cntNext = cnt + CW'(1);
               end
            end
            SHOW_LO: begin
               if (cnt == HOLD_LAST) begin
                  cntNext = '0;
                  if (HAS_GAP) stateNext = GAP_LO;
                  else         wrap      = 1'b1;
               end else begin
                  cntNext = cnt + CW'(1);
               end
            end
            GAP_LO: begin
               if (cnt == GAP_LAST) begin
                  cntNext = '0;
                  wrap    = 1'b1;
               end else begin
                  cntNext = cnt + CW'(1);
               end
            end
            default: begin
               stateNext = IDLE;
               cntNext   = '0;
            end
         endcase

         // A word offered on the wrap edge with nothing pending goes straight to disp.
         if (wrap) begin
            stateNext     = SHOW_HI;
            pendValidNext = 1'b0;
            if (pendValid)  dispNext = pend;
            else if (xfer)  dispNext = load_data;
         end
      end
   end

   always_comb begin
      leftNext  = 4'h0;
      rightNext = 4'h0;
      blankNext = 1'b1;
      pageNext  = 1'b0;
      case (stateNext)
         SHOW_HI: begin
            leftNext  = dispNext[15:12];
            rightNext = dispNext[11:8];
            blankNext = 1'b0;
         end
         SHOW_LO: begin
            leftNext  = dispNext[7:4];
            rightNext = dispNext[3:0];
            blankNext = 1'b0;
            pageNext  = 1'b1;
         end
         GAP_LO:  pageNext = 1'b1;
         default: pageNext = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         disp        <= '0;
         pend        <= '0;
         pendValid   <= 1'b0;
         digit_left  <= 4'h0;
         digit_right <= 4'h0;
         blank       <= 1'b1;
         page        <= 1'b0;
      end else begin
         state       <= stateNext;
         cnt         <= cntNext;
         disp        <= dispNext;
         pend        <= pendNext;
         pendValid   <= pendValidNext;
         digit_left  <= leftNext;
         digit_right <= rightNext;
         blank       <= blankNext;
         page        <= pageNext;
      end
   end

endmodule

// File: tb/tb_seven_segment_pager.sv
// Bench for seven_segment_pager: one instance with a gap and one without, driven with the same
// stimulus and compared every cycle against a position-in-period reference model.
module tb_seven_segment_pager;

   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst, clear, loadValid;
   logic [15:0] loadData;
   logic        ready0, ready1, blank0, blank1, page0, page1;
   logic [3:0]  left0, right0, left1, right1;

   seven_segment_pager #(.HOLD_CYCLES(H), .GAP_CYCLES(2)) dutGap (
      .clk(clk), .rst(rst), .clear(clear), .load_valid(loadValid), .load_data(loadData),
      .load_ready(ready0), .digit_left(left0), .digit_right(right0), .blank(blank0), .page(page0));

   seven_segment_pager #(.HOLD_CYCLES(H), .GAP_CYCLES(0)) dutNoGap (
      .clk(clk), .rst(rst), .clear(clear), .load_valid(loadValid), .load_data(loadData),
      .load_ready(ready1), .digit_left(left1), .digit_right(right1), .blank(blank1), .page(page1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit          mActive[2];
   int          mPos[2];
   logic [15:0] mDisp[2];
   logic [15:0] mPend[2];
   bit          mPendValid[2];

   function automatic int gapOf(int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mActive[i] = 0; mPos[i] = 0; mDisp[i] = '0; mPend[i] = '0; mPendValid[i] = 0;
      end
   endtask

   // Model advances one edge using the inputs present at that edge.
   task automatic modelEdge();
      for (int i = 0; i < 2; i++) begin
         int  period = 2 * (H + gapOf(i));
         bit  xfer   = loadValid && !mPendValid[i];
         if (clear) begin
            mActive[i] = 0; mPos[i] = 0; mPendValid[i] = 0;
         end else if (!mActive[i]) begin
            if (xfer) begin mActive[i] = 1; mPos[i] = 0; mDisp[i] = loadData; end
         end else if (mPos[i] == period - 1) begin
            mPos[i] = 0;
            if (mPendValid[i]) begin mDisp[i] = mPend[i]; mPendValid[i] = 0; end
            else if (xfer) mDisp[i] = loadData;
         end else begin
            mPos[i]++;
            if (xfer) begin mPend[i] = loadData; mPendValid[i] = 1; end
         end
      end
   endtask

   function automatic logic [10:0] expOut(int i);
      int g = gapOf(i);
      int p = mPos[i];
      logic [15:0] d = mDisp[i];
      logic rdy = !mPendValid[i];
      if (!mActive[i])     return {8'h00, 1'b1, 1'b0, rdy};
      if (p < H)           return {d[15:12], d[11:8], 1'b0, 1'b0, rdy};
      if (p < H + g)       return {8'h00, 1'b1, 1'b0, rdy};
      if (p < 2 * H + g)   return {d[7:4], d[3:0], 1'b0, 1'b1, rdy};
      return {8'h00, 1'b1, 1'b1, rdy};
   endfunction

   task automatic checkAll();
      logic [10:0] e0, e1;
      e0 = expOut(0);
      e1 = expOut(1);
      check("gap_outputs",   {left0, right0, blank0, page0, ready0}, e0);
      check("nogap_outputs", {left1, right1, blank1, page1, ready1}, e1);
   endtask

   task automatic cycle(input bit v, input logic [15:0] d, input bit c);
      loadValid = v; loadData = d; clear = c;
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
      loadValid = 0; clear = 0;
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) cycle(0, 16'h0, 0);
   endtask

   typedef struct {
      bit          v;
      logic [15:0] d;
      logic [3:0]  l, r;
      bit          b, p, rdy;
   } vec_t;

   vec_t tbl[$];

   initial begin
      tbl.push_back('{1, 16'hBEEF, 4'hB, 4'hE, 0, 0, 1});
      for (int k = 1; k <= 3; k++)  tbl.push_back('{0, 16'h0, 4'hB, 4'hE, 0, 0, 1});
      for (int k = 4; k <= 5; k++)  tbl.push_back('{0, 16'h0, 4'h0, 4'h0, 1, 0, 1});
      for (int k = 6; k <= 9; k++)  tbl.push_back('{0, 16'h0, 4'hE, 4'hF, 0, 1, 1});
      for (int k = 10; k <= 11; k++) tbl.push_back('{0, 16'h0, 4'h0, 4'h0, 1, 1, 1});
      tbl.push_back('{0, 16'h0, 4'hB, 4'hE, 0, 0, 1});

      rst = 1; clear = 0; loadValid = 0; loadData = '0;
      modelReset();
      #12;
      check("reset_left",  left0, 4'h0);
      check("reset_right", right0, 4'h0);
      check("reset_blank", blank0, 1'b1);
      check("reset_page",  page0, 1'b0);
      check("reset_ready", ready0, 1'b1);
      @(negedge clk);
      rst = 0;

      // Basic loop, compared against hand-written expectations
      foreach (tbl[k]) begin
         cycle(tbl[k].v, tbl[k].d, 0);
         check("tbl_left",  left0,  tbl[k].l);
         check("tbl_right", right0, tbl[k].r);
         check("tbl_blank", blank0, tbl[k].b);
         check("tbl_page",  page0,  tbl[k].p);
         check("tbl_ready", ready0, tbl[k].rdy);
      end
      cycle(0, 16'h0, 1);

      // Pending word stalls until the wrap edge
      cycle(1, 16'hBEEF, 0);
      cycle(0, 16'h0, 0);
      for (int e = 2; e <= 12; e++) begin
         cycle(e == 2, 16'h1234, 0);
         if (e < 12) check("pend_ready_low", ready0, 1'b0);
      end
      check("pend_ready_high", ready0, 1'b1);
      check("pend_left",  left0,  4'h1);
      check("pend_right", right0, 4'h2);
      cycle(0, 16'h0, 1);

      // Bypass on the wrap edge
      cycle(1, 16'hBEEF, 0);
      idleCycles(11);
      cycle(1, 16'hCAFE, 0);
      check("bypass_left",  left0,  4'hC);
      check("bypass_right", right0, 4'hA);
      check("bypass_ready", ready0, 1'b1);
      cycle(0, 16'h0, 1);

      // No-gap instance never blanks once running
      cycle(1, 16'h00FF, 0);
      check("nogap_first_page", page1, 1'b0);
      for (int e = 1; e <= 10; e++) begin
         cycle(0, 16'h0, 0);
         check("nogap_blank", blank1, 1'b0);
         if (e == 4) begin
            check("nogap_lo_left", left1, 4'hF);
            check("nogap_lo_page", page1, 1'b1);
         end
      end
      cycle(0, 16'h0, 1);

      // Clear with a word pending, then restart
      cycle(1, 16'hBEEF, 0);
      cycle(0, 16'h0, 0);
      cycle(1, 16'h1234, 0);
      idleCycles(3);
      cycle(0, 16'h0, 1);
      check("clear_blank", blank0, 1'b1);
      check("clear_page",  page0,  1'b0);
      check("clear_ready", ready0, 1'b1);
      cycle(1, 16'h5A5A, 0);
      check("restart_left",  left0,  4'h5);
      check("restart_right", right0, 4'hA);
      check("restart_blank", blank0, 1'b0);
      cycle(0, 16'h0, 1);

      // Async reset mid-SHOW_LO with a word pending
      cycle(1, 16'hBEEF, 0);
      cycle(0, 16'h0, 0);
      cycle(1, 16'h1234, 0);
      idleCycles(5);
      check("pre_reset_page", page0, 1'b1);
      #3 rst = 1;
      #1;
      modelReset();
      check("rst_left",  left0,  4'h0);
      check("rst_right", right0, 4'h0);
      check("rst_blank", blank0, 1'b1);
      check("rst_page",  page0,  1'b0);
      check("rst_ready", ready0, 1'b1);
      checkAll();
      @(negedge clk);
      rst = 0;
      idleCycles(4);

      // Randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         bit v = ($urandom_range(0, 99) < 30);
         bit c = ($urandom_range(0, 99) < 2);
         cycle(v, 16'($urandom), c);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
